// File: rtl/scroll_ascii_7seg_pkg.sv
// Shared types and constants for the scrolling ASCII feeder
// of the multiplexed 7-segment display driver.
package scroll_ascii_7seg_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  // Active-low a..g,dp; bit7=a, bit0=dp
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_UNK   = 8'hFE;
  localparam logic [7:0] SEG_DASH  = 8'hFD;

  localparam logic [7:0] ASC_BS = 8'h08;
  localparam logic [7:0] ASC_CR = 8'h0D;

endpackage

// File: rtl/scroll_ascii_7seg_ascii_a_7seg.sv
// Combinational ASCII to active-low segment pattern lookup.
// Letters are matched case-insensitively.
module ascii_a_7seg
  import scroll_ascii_7seg_pkg::*;
#(
  parameter logic [7:0] BLANK_PAT = SEG_BLANK,
  parameter logic [7:0] UNK_PAT   = SEG_UNK
) (
  input  logic [7:0] ascii,
  output logic [7:0] seg
);

  logic [7:0] up;

  always_comb begin
    up = ascii;
    if (ascii >= 8'h61 && ascii <= 8'h7A)
      up = ascii & 8'hDF;
    case (up)
      8'h30:   seg = 8'h03;
      8'h31:   seg = 8'h9F;
      8'h32:   seg = 8'h25;
      8'h33:   seg = 8'h0D;
      8'h34:   seg = 8'h99;
      8'h35:   seg = 8'h49;
      8'h36:   seg = 8'h41;
      8'h37:   seg = 8'h1F;
      8'h38:   seg = 8'h01;
      8'h39:   seg = 8'h09;
      8'h41:   seg = 8'h11;
      8'h42:   seg = 8'hC1;
      8'h43:   seg = 8'h63;
      8'h44:   seg = 8'h85;
      8'h45:   seg = 8'h61;
      8'h46:   seg = 8'h71;
      8'h48:   seg = 8'h91;
      8'h4C:   seg = 8'hE3;
      8'h50:   seg = 8'h31;
      8'h55:   seg = 8'h83;
      8'h2D:   seg = SEG_DASH;
      8'h5F:   seg = 8'hEF;
      8'h20:   seg = BLANK_PAT;
      default: seg = UNK_PAT;
    endcase
  end

endmodule

// File: rtl/scroll_ascii_7seg.sv
// Scrolling 4-digit shadow that rewrites all display buffers
// through the driver's load/datai/bufdestino port per character.
module scroll_ascii_7seg
  import scroll_ascii_7seg_pkg::*;
#(
  parameter int         INIT_WAIT = 4,
  parameter logic [7:0] BLANK_PAT = SEG_BLANK,
  parameter logic [7:0] UNK_PAT   = SEG_UNK
) (
  input  logic       reloj,
  input  logic       reset,
  input  logic       char_valid,
  input  logic [7:0] char_ascii,
  input  logic       clear,
  output logic       char_ready,
  output logic       load,
  output logic [7:0] datai,
  output logic [1:0] bufdestino,
  output logic       busy
);

  localparam int CW = (INIT_WAIT > 1) ? $clog2(INIT_WAIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(INIT_WAIT - 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [3:0][7:0] shadow;
  logic [3:0][7:0] shadow_nx;
  logic [7:0]      pat;
  logic            accept;
  logic            is_clr;
  logic            is_bs;

  ascii_a_7seg #(
    .BLANK_PAT (BLANK_PAT),
    .UNK_PAT   (UNK_PAT)
  ) u_lut (
    .ascii (char_ascii),
    .seg   (pat)
  );

  assign accept = char_ready && (char_valid || clear);
  assign is_clr = clear || (char_ascii == ASC_CR);
  assign is_bs  = !is_clr && (char_ascii == ASC_BS);

  always_comb begin
    shadow_nx = shadow;
    unique case (1'b1)
      is_clr:  shadow_nx = {4{BLANK_PAT}};
      is_bs:   shadow_nx = {BLANK_PAT, shadow[3:1]};
      default: shadow_nx = {shadow[2:0], pat};
    endcase
  end

  // bufdestino doubles as the write index, counting 3 down to 0
  always_ff @(posedge reloj or negedge reset) begin
    if (!reset) begin
      state      <= ST_INIT;
      cnt        <= '0;
      shadow     <= {4{BLANK_PAT}};
      load       <= 1'b0;
      datai      <= 8'hFF;
      bufdestino <= 2'd0;
      char_ready <= 1'b0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        ST_INIT: begin
          if (cnt == CNT_LAST) begin
            state      <= ST_IDLE;
            char_ready <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (accept) begin
            shadow     <= shadow_nx;
            state      <= ST_WRITE;
            char_ready <= 1'b0;
            busy       <= 1'b1;
            load       <= 1'b1;
            bufdestino <= 2'd3;
            datai      <= shadow_nx[3];
          end
        end
        ST_WRITE: begin
          if (bufdestino == 2'd0) begin
            state      <= ST_IDLE;
            load       <= 1'b0;
            busy       <= 1'b0;
            char_ready <= 1'b1;
          end else begin
            bufdestino <= bufdestino - 2'd1;
            datai      <= shadow[bufdestino - 2'd1];
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_scroll_ascii_7seg.sv
// Bench for scroll_ascii_7seg: vector table, hand sequences
// and random characters against a queue-based display model.
module tb_scroll_ascii_7seg;

  logic       reloj = 1'b0;
  logic       reset = 1'b0;
  logic       char_valid = 1'b0;
  logic [7:0] char_ascii = 8'h00;
  logic       clear = 1'b0;
  logic       char_ready;
  logic       load;
  logic [7:0] datai;
  logic [1:0] bufdestino;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int load_cnt = 0;

  logic [7:0] disp [4] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
  logic [7:0] q [$];

  typedef struct {
    logic [7:0]      ch;
    bit              clr;
    logic [3:0][7:0] exp;
  } vec_t;

  vec_t tbl [16];

  scroll_ascii_7seg dut (
    .reloj      (reloj),
    .reset      (reset),
    .char_valid (char_valid),
    .char_ascii (char_ascii),
    .clear      (clear),
    .char_ready (char_ready),
    .load       (load),
    .datai      (datai),
    .bufdestino (bufdestino),
    .busy       (busy)
  );

  always #5 reloj = ~reloj;

  always @(posedge reloj) begin
    if (load) begin
      disp[bufdestino] = datai;
      load_cnt++;
    end
  end

  function automatic logic [7:0] ref_pat(input logic [7:0] c);
    string      keys;
    logic [7:0] vals [23];
    logic [7:0] u;
    keys = "0123456789ABCDEFHLPU-_ ";
    vals = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41,
             8'h1F, 8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85,
             8'h61, 8'h71, 8'h91, 8'hE3, 8'h31, 8'h83, 8'hFD,
             8'hEF, 8'hFF};
    u = c;
    if (c >= "a" && c <= "z") u = c - 8'd32;
    for (int i = 0; i < keys.len(); i++)
      if (keys[i] == u) return vals[i];
    return 8'hFE;
  endfunction

  task automatic model(input logic [7:0] c, input bit clr);
    if (clr || c == 8'h0D) begin
      q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    end else if (c == 8'h08) begin
      void'(q.pop_back());
      q.push_front(8'hFF);
    end else begin
      void'(q.pop_front());
      q.push_back(ref_pat(c));
    end
  endtask

  function automatic logic [3:0][7:0] model_exp();
    return {q[0], q[1], q[2], q[3]};
  endfunction

  function automatic vec_t mk(input logic [7:0] c, input bit clr,
                              input logic [31:0] e);
    vec_t v;
    v.ch = c;
    v.clr = clr;
    v.exp = e;
    return v;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!char_ready && n < 50) begin
      @(posedge reloj); #1;
      n++;
    end
    if (!char_ready) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout char_ready=%0b want 1", char_ready);
    end
  endtask

  // Called #1 after the accepting edge
  task automatic expect_writes(input logic [3:0][7:0] exp, input bit poke);
    logic [1:0] bd;
    for (int k = 0; k < 4; k++) begin
      bd = 2'(3 - k);
      checks++;
      if (load !== 1'b1 || busy !== 1'b1 || char_ready !== 1'b0 ||
          bufdestino !== bd || datai !== exp[bd]) begin
        failures++;
        $display("FAIL write%0d load=%b busy=%b rdy=%b bd=%0d datai=%h want 1 1 0 %0d %h",
                 k, load, busy, char_ready, bufdestino, datai, bd, exp[bd]);
      end
      if (poke && k == 1) clear = 1'b1;
      if (poke && k == 2) clear = 1'b0;
      @(posedge reloj); #1;
    end
    checks++;
    if (load !== 1'b0 || busy !== 1'b0 || char_ready !== 1'b1) begin
      failures++;
      $display("FAIL after_write load=%b busy=%b rdy=%b want 0 0 1",
               load, busy, char_ready);
    end
  endtask

  task automatic send(input logic [7:0] c, input bit clr,
                      input logic [3:0][7:0] exp, input bit poke);
    wait_ready();
    char_valid = 1'b1;
    char_ascii = c;
    clear = clr;
    @(posedge reloj); #1;
    char_valid = 1'b0;
    clear = 1'b0;
    expect_writes(exp, poke);
  endtask

  task automatic do_reset();
    int n = 0;
    int l0;
    reset = 1'b0;
    char_valid = 1'b0;
    clear = 1'b0;
    q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    repeat (2) @(posedge reloj);
    #1;
    checks++;
    if (load !== 1'b0 || datai !== 8'hFF || bufdestino !== 2'd0 ||
        char_ready !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_vals load=%b datai=%h bd=%0d rdy=%b busy=%b want 0 ff 0 0 0",
               load, datai, bufdestino, char_ready, busy);
    end
    l0 = load_cnt;
    reset = 1'b1;
    while (!char_ready && n < 20) begin
      @(posedge reloj); #1;
      n++;
    end
    checks++;
    if (n != 4) begin
      failures++;
      $display("FAIL init_len cycles=%0d want 4", n);
    end
    checks++;
    if (load_cnt != l0) begin
      failures++;
      $display("FAIL init_load loads=%0d want 0", load_cnt - l0);
    end
  endtask

  initial begin
    string      pool;
    string      s;
    logic [7:0] c;
    bit         clr;
    int         r;
    int         cyc;
    int         n;
    int         prev;

    tbl[0]  = mk(8'h31, 0, 32'hFFFFFF9F);
    tbl[1]  = mk(8'h32, 0, 32'hFFFF9F25);
    tbl[2]  = mk(8'h08, 0, 32'hFFFFFF9F);
    tbl[3]  = mk(8'h23, 0, 32'hFFFF9FFE);
    tbl[4]  = mk(8'h38, 1, 32'hFFFFFFFF);
    tbl[5]  = mk(8'h61, 0, 32'hFFFFFF11);
    tbl[6]  = mk(8'h62, 0, 32'hFFFF11C1);
    tbl[7]  = mk(8'h68, 0, 32'hFF11C191);
    tbl[8]  = mk(8'h20, 0, 32'h11C191FF);
    tbl[9]  = mk(8'h0D, 0, 32'hFFFFFFFF);
    tbl[10] = mk(8'h2D, 0, 32'hFFFFFFFD);
    tbl[11] = mk(8'h5F, 0, 32'hFFFFFDEF);
    tbl[12] = mk(8'h70, 0, 32'hFFFDEF31);
    tbl[13] = mk(8'h75, 0, 32'hFDEF3183);
    tbl[14] = mk(8'h4C, 0, 32'hEF3183E3);
    tbl[15] = mk(8'h67, 0, 32'h3183E3FE);

    do_reset();

    foreach (tbl[i]) begin
      send(tbl[i].ch, tbl[i].clr, tbl[i].exp, 1'b0);
      model(tbl[i].ch, tbl[i].clr);
    end

    // Held valid: each new char only after ready is seen
    send(8'h38, 1'b1, 32'hFFFFFFFF, 1'b0);
    model(8'h38, 1'b1);
    s = "12345";
    char_valid = 1'b1;
    char_ascii = s[0];
    cyc = 0;
    n = 0;
    prev = -1;
    while (n < 5 && cyc < 200) begin
      if (char_ready) begin
        if (prev >= 0) begin
          checks++;
          if (cyc - prev != 5) begin
            failures++;
            $display("FAIL accept_gap gap=%0d want 5", cyc - prev);
          end
        end
        model(s[n], 1'b0);
        prev = cyc;
        n++;
        @(posedge reloj); #1;
        cyc++;
        if (n < 5) char_ascii = s[n];
      end else begin
        @(posedge reloj); #1;
        cyc++;
      end
    end
    char_valid = 1'b0;
    if (n < 5) begin
      checks++;
      failures++;
      $display("FAIL scroll_timeout accepts=%0d want 5", n);
    end else begin
      expect_writes(32'h250D9949, 1'b0);
    end

    // Clear pulsed while busy must be dropped
    model(8'h39, 1'b0);
    send(8'h39, 1'b0, model_exp(), 1'b1);
    model(8'h30, 1'b0);
    send(8'h30, 1'b0, model_exp(), 1'b0);

    pool = "0123456789abcdefABCDEFhlpuHLPU-_ #gz";
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      c = 8'h08;
      else if (r == 1) c = 8'h0D;
      else if (r <= 3) c = 8'($urandom_range(0, 255));
      else             c = pool[$urandom_range(0, pool.len() - 1)];
      clr = ($urandom_range(0, 7) == 0);
      model(c, clr);
      send(c, clr, model_exp(), 1'b0);
    end

    // Reset in the middle of a write sequence
    wait_ready();
    char_valid = 1'b1;
    char_ascii = 8'h35;
    @(posedge reloj); #1;
    char_valid = 1'b0;
    @(posedge reloj); #1;
    checks++;
    if (load !== 1'b1) begin
      failures++;
      $display("FAIL midwrite_load load=%b want 1", load);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (load !== 1'b0 || busy !== 1'b0 || char_ready !== 1'b0) begin
      failures++;
      $display("FAIL async_abort load=%b busy=%b rdy=%b want 0 0 0",
               load, busy, char_ready);
    end
    do_reset();
    model(8'h37, 1'b0);
    send(8'h37, 1'b0, 32'hFFFFFF1F, 1'b0);

    for (int b = 0; b < 4; b++) begin
      checks++;
      if (disp[b] !== q[3 - b]) begin
        failures++;
        $display("FAIL disp%0d got=%h want=%h", b, disp[b], q[3 - b]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
